// File: rtl/control_sequencer_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, state encodings,
// ALU select bit positions and the opcode classes the decoder reports.
package control_sequencer_pkg;

   localparam int NREG    = 16;
   localparam int IR_W    = 32;
   localparam int STATE_W = 4;
   localparam int ALU_W   = 14;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_HALT = 4'd7
   } state_e;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_SHR  = 5'b00100;
   localparam logic [4:0] OP_SHRA = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // alu_sel bit positions; bit 13 is a spare and stays 0
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_AND  = 2;
   localparam int ALU_OR   = 3;
   localparam int ALU_SHR  = 4;
   localparam int ALU_SHRA = 5;
   localparam int ALU_SHL  = 6;
   localparam int ALU_ROR  = 7;
   localparam int ALU_ROL  = 8;
   localparam int ALU_NEG  = 9;
   localparam int ALU_NOT  = 10;
   localparam int ALU_MUL  = 11;
   localparam int ALU_DIV  = 12;

   typedef enum logic [2:0] {
      CLS_OP3     = 3'd0,
      CLS_MULDIV  = 3'd1,
      CLS_UNARY   = 3'd2,
      CLS_NOP     = 3'd3,
      CLS_HALT    = 3'd4,
      CLS_ILLEGAL = 3'd5
   } op_class_e;

endpackage

// File: rtl/control_sequencer_ir_field_decode.sv
// Splits the instruction word into an opcode class, a one-hot ALU select and
// one-hot decodes of the three register fields.
module ir_field_decode
   import control_sequencer_pkg::*;
(
   input  logic [IR_W-1:0]  ir_i,
   output op_class_e        op_class_o,
   output logic [ALU_W-1:0] alu_sel_o,
   output logic [NREG-1:0]  ra_dec_o,
   output logic [NREG-1:0]  rb_dec_o,
   output logic [NREG-1:0]  rc_dec_o
);

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       unused_low;

   assign opcode     = ir_i[31:27];
   assign ra         = ir_i[26:23];
   assign rb         = ir_i[22:19];
   assign rc         = ir_i[18:15];
   assign unused_low = ^ir_i[14:0];

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg_dec
         assign ra_dec_o[gi] = (ra == 4'(gi));
         assign rb_dec_o[gi] = (rb == 4'(gi));
         assign rc_dec_o[gi] = (rc == 4'(gi));
      end
   endgenerate

   always_comb begin
      op_class_o = CLS_ILLEGAL;
      alu_sel_o  = '0;
      case (opcode)
         OP_ADD:  begin op_class_o = CLS_OP3;    alu_sel_o[ALU_ADD]  = 1'b1; end
         OP_SUB:  begin op_class_o = CLS_OP3;    alu_sel_o[ALU_SUB]  = 1'b1; end
         OP_AND:  begin op_class_o = CLS_OP3;    alu_sel_o[ALU_AND]  = 1'b1; end
         OP_OR:   begin op_class_o = CLS_OP3;    alu_sel_o[ALU_OR]   = 1'b1; end
         OP_SHR:  begin op_class_o = CLS_OP3;    alu_sel_o[ALU_SHR]  = 1'b1; end
         OP_SHRA: begin op_class_o = CLS_OP3;    alu_sel_o[ALU_SHRA] = 1'b1; end
         OP_SHL:  begin op_class_o = CLS_OP3;    alu_sel_o[ALU_SHL]  = 1'b1; end
         OP_ROR:  begin op_class_o = CLS_OP3;    alu_sel_o[ALU_ROR]  = 1'b1; end
         OP_ROL:  begin op_class_o = CLS_OP3;    alu_sel_o[ALU_ROL]  = 1'b1; end
         OP_MUL:  begin op_class_o = CLS_MULDIV; alu_sel_o[ALU_MUL]  = 1'b1; end
         OP_DIV:  begin op_class_o = CLS_MULDIV; alu_sel_o[ALU_DIV]  = 1'b1; end
         OP_NEG:  begin op_class_o = CLS_UNARY;  alu_sel_o[ALU_NEG]  = 1'b1; end
         OP_NOT:  begin op_class_o = CLS_UNARY;  alu_sel_o[ALU_NOT]  = 1'b1; end
         OP_NOP:  op_class_o = CLS_NOP;
         OP_HALT: op_class_o = CLS_HALT;
         default: op_class_o = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer producing the datapath strobes as
// Moore decodes of the state register and the (already loaded) IR.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic               clock,
   input  logic               clear,
   input  logic               run,
   input  logic [IR_W-1:0]    IR,
   output logic [NREG-1:0]    Rin,
   output logic [NREG-1:0]    Rout,
   output logic               PCin,
   output logic               IRin,
   output logic               Yin,
   output logic               Zin,
   output logic               MARin,
   output logic               MDRin,
   output logic               HIin,
   output logic               LOin,
   output logic               PCout,
   output logic               MDRout,
   output logic               Zlowout,
   output logic               Zhighout,
   output logic               HIout,
   output logic               LOout,
   output logic               InPortout,
   output logic               Cout,
   output logic               IncPC,
   output logic               Read,
   output logic [ALU_W-1:0]   alu_sel,
   output logic               instr_done,
   output logic               halted,
   output logic               illegal,
   output logic [STATE_W-1:0] state_dbg
);

   state_e           state_q, state_d, after_done;
   op_class_e        op_class;
   logic [ALU_W-1:0] alu_dec;
   logic [NREG-1:0]  ra_dec, rb_dec, rc_dec;

   ir_field_decode u_decode (
      .ir_i       (IR),
      .op_class_o (op_class),
      .alu_sel_o  (alu_dec),
      .ra_dec_o   (ra_dec),
      .rb_dec_o   (rb_dec),
      .rc_dec_o   (rc_dec)
   );

   always_ff @(posedge clock) begin
      if (clear) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // run is only consulted at instruction boundaries, so dropping it never aborts
   assign after_done = run ? ST_T0 : ST_IDLE;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (run) state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1:   state_d = ST_T2;
         ST_T2:   state_d = ST_T3;
         ST_T3: begin
            case (op_class)
               CLS_OP3, CLS_MULDIV, CLS_UNARY: state_d = ST_T4;
               CLS_HALT:                       state_d = ST_HALT;
               default:                        state_d = after_done;
            endcase
         end
         ST_T4: begin
            if (op_class == CLS_OP3 || op_class == CLS_MULDIV) state_d = ST_T5;
            else                                               state_d = after_done;
         end
         ST_T5:   state_d = after_done;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      Rin = '0;  Rout = '0;  alu_sel = '0;
      PCin = 1'b0;  IRin = 1'b0;  Yin = 1'b0;  Zin = 1'b0;
      MARin = 1'b0;  MDRin = 1'b0;  HIin = 1'b0;  LOin = 1'b0;
      PCout = 1'b0;  MDRout = 1'b0;  Zlowout = 1'b0;  Zhighout = 1'b0;
      HIout = 1'b0;  LOout = 1'b0;  InPortout = 1'b0;  Cout = 1'b0;
      IncPC = 1'b0;  Read = 1'b0;
      instr_done = 1'b0;  halted = 1'b0;  illegal = 1'b0;
      state_dbg = '0;
      if (!clear) begin
         state_dbg = state_q;
         case (state_q)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; end
            ST_T1: begin PCout = 1'b1; IncPC = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
               case (op_class)
                  CLS_OP3:    begin Rout = rb_dec; Yin = 1'b1; end
                  CLS_MULDIV: begin Rout = ra_dec; Yin = 1'b1; end
                  CLS_UNARY:  begin Rout = rb_dec; alu_sel = alu_dec; Zin = 1'b1; end
                  CLS_NOP,
                  CLS_HALT:   instr_done = 1'b1;
                  default:    begin instr_done = 1'b1; illegal = 1'b1; end
               endcase
            end
            ST_T4: begin
               case (op_class)
                  CLS_OP3:    begin Rout = rc_dec; alu_sel = alu_dec; Zin = 1'b1; end
                  CLS_MULDIV: begin Rout = rb_dec; alu_sel = alu_dec; Zin = 1'b1; end
                  CLS_UNARY:  begin Zlowout = 1'b1; Rin = ra_dec; instr_done = 1'b1; end
                  default:    ;
               endcase
            end
            ST_T5: begin
               case (op_class)
                  CLS_OP3:    begin Zlowout = 1'b1; Rin = ra_dec; instr_done = 1'b1; end
                  CLS_MULDIV: begin HIin = 1'b1; LOin = 1'b1; instr_done = 1'b1; end
                  default:    ;
               endcase
            end
            ST_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: stimulus pushes the hand-computed per-cycle output vector into a
// scoreboard queue; a negedge monitor pops and compares against the DUT.
module tb_control_sequencer;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [13:0] alu;
      logic [20:0] fl;
   } vec_t;

   // flag order: PCin IRin Yin Zin MARin MDRin HIin LOin PCout MDRout Zlowout Zhighout
   //             HIout LOout InPortout Cout IncPC Read instr_done halted illegal
   localparam logic [20:0] F_PCIN   = 21'h1 << 20;
   localparam logic [20:0] F_IRIN   = 21'h1 << 19;
   localparam logic [20:0] F_YIN    = 21'h1 << 18;
   localparam logic [20:0] F_ZIN    = 21'h1 << 17;
   localparam logic [20:0] F_MARIN  = 21'h1 << 16;
   localparam logic [20:0] F_MDRIN  = 21'h1 << 15;
   localparam logic [20:0] F_HIIN   = 21'h1 << 14;
   localparam logic [20:0] F_LOIN   = 21'h1 << 13;
   localparam logic [20:0] F_PCOUT  = 21'h1 << 12;
   localparam logic [20:0] F_MDROUT = 21'h1 << 11;
   localparam logic [20:0] F_ZLOW   = 21'h1 << 10;
   localparam logic [20:0] F_INCPC  = 21'h1 << 4;
   localparam logic [20:0] F_READ   = 21'h1 << 3;
   localparam logic [20:0] F_DONE   = 21'h1 << 2;
   localparam logic [20:0] F_HALTED = 21'h1 << 1;
   localparam logic [20:0] F_ILL    = 21'h1;

   localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                          S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_HALT = 4'd7;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        run   = 1'b0;
   logic [31:0] IR    = 32'h0;
   logic [15:0] Rin, Rout;
   logic        PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin;
   logic        PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout;
   logic        IncPC, Read, instr_done, halted, illegal;
   logic [13:0] alu_sel;
   logic [3:0]  state_dbg;

   control_sequencer dut (
      .clock(clock), .clear(clear), .run(run), .IR(IR),
      .Rin(Rin), .Rout(Rout),
      .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin),
      .HIin(HIin), .LOin(LOin),
      .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
      .IncPC(IncPC), .Read(Read), .alu_sel(alu_sel),
      .instr_done(instr_done), .halted(halted), .illegal(illegal), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   vec_t  exp_q[$];
   string nm_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic vec_t mk(input logic [3:0] st, input logic [15:0] rin,
                               input logic [15:0] rout, input logic [13:0] alu,
                               input logic [20:0] fl);
      vec_t v;
      v.st = st; v.rin = rin; v.rout = rout; v.alu = alu; v.fl = fl;
      return v;
   endfunction

   // one cycle: drive inputs, queue what the DUT must show this cycle
   task automatic step(input vec_t e, input string nm, input logic r, input logic c);
      run   = r;
      clear = c;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge clock);
      #1;
   endtask

   task automatic fetch(input string nm, input logic [31:0] ir);
      IR = ir;
      step(mk(S_T0, 16'h0, 16'h0, 14'h0, F_PCOUT | F_MARIN), {nm, "_T0"}, 1'b1, 1'b0);
      step(mk(S_T1, 16'h0, 16'h0, 14'h0, F_PCOUT | F_INCPC | F_PCIN | F_READ | F_MDRIN),
           {nm, "_T1"}, 1'b1, 1'b0);
      step(mk(S_T2, 16'h0, 16'h0, 14'h0, F_MDROUT | F_IRIN), {nm, "_T2"}, 1'b1, 1'b0);
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         vec_t  e, a;
         string nm;
         e  = exp_q.pop_front();
         nm = nm_q.pop_front();
         a  = {state_dbg, Rin, Rout, alu_sel,
               {PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, PCout, MDRout, Zlowout,
                Zhighout, HIout, LOout, InPortout, Cout, IncPC, Read, instr_done, halted, illegal}};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%h rin=%h rout=%h alu=%h fl=%h, expected st=%h rin=%h rout=%h alu=%h fl=%h",
                     nm, a.st, a.rin, a.rout, a.alu, a.fl, e.st, e.rin, e.rout, e.alu, e.fl);
         end else begin
            $display("check %s ok: st=%h rin=%h rout=%h alu=%h fl=%h",
                     nm, a.st, a.rin, a.rout, a.alu, a.fl);
         end
      end
   end

   vec_t zero;

   initial begin
      zero = mk(S_IDLE, 16'h0, 16'h0, 14'h0, 21'h0);
      @(posedge clock);
      #1;
      // reset and idle hold
      step(zero, "clear0", 1'b0, 1'b1);
      step(zero, "clear1", 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(zero, "idle_hold", 1'b0, 1'b0);
      step(zero, "idle_go", 1'b1, 1'b0);

      // add R5,R2,R4
      fetch("add", 32'h02920000);
      step(mk(S_T3, 16'h0, 16'h0004, 14'h0, F_YIN), "add_T3", 1'b1, 1'b0);
      step(mk(S_T4, 16'h0, 16'h0010, 14'h0001, F_ZIN), "add_T4", 1'b1, 1'b0);
      step(mk(S_T5, 16'h0020, 16'h0, 14'h0, F_ZLOW | F_DONE), "add_T5", 1'b1, 1'b0);

      // mul R3,R1
      fetch("mul", 32'h79880000);
      step(mk(S_T3, 16'h0, 16'h0008, 14'h0, F_YIN), "mul_T3", 1'b1, 1'b0);
      step(mk(S_T4, 16'h0, 16'h0002, 14'h0800, F_ZIN), "mul_T4", 1'b1, 1'b0);
      step(mk(S_T5, 16'h0, 16'h0, 14'h0, F_HIIN | F_LOIN | F_DONE), "mul_T5", 1'b1, 1'b0);

      // neg R1,R6: five cycles, straight back to T0
      fetch("neg", 32'h88B00000);
      step(mk(S_T3, 16'h0, 16'h0040, 14'h0200, F_ZIN), "neg_T3", 1'b1, 1'b0);
      step(mk(S_T4, 16'h0002, 16'h0, 14'h0, F_ZLOW | F_DONE), "neg_T4", 1'b1, 1'b0);

      // not R3,R3 (Ra = Rb)
      fetch("not", 32'h91980000);
      step(mk(S_T3, 16'h0, 16'h0008, 14'h0400, F_ZIN), "not_T3", 1'b1, 1'b0);
      step(mk(S_T4, 16'h0008, 16'h0, 14'h0, F_ZLOW | F_DONE), "not_T4", 1'b1, 1'b0);

      // rol R15,R0,R15: index extremes
      fetch("rol", 32'h47878000);
      step(mk(S_T3, 16'h0, 16'h0001, 14'h0, F_YIN), "rol_T3", 1'b1, 1'b0);
      step(mk(S_T4, 16'h0, 16'h8000, 14'h0100, F_ZIN), "rol_T4", 1'b1, 1'b0);
      step(mk(S_T5, 16'h8000, 16'h0, 14'h0, F_ZLOW | F_DONE), "rol_T5", 1'b1, 1'b0);

      // sub R7,R8,R9 with run dropped during T1: must still complete
      IR = 32'h0BC48000;
      step(mk(S_T0, 16'h0, 16'h0, 14'h0, F_PCOUT | F_MARIN), "sub_T0", 1'b1, 1'b0);
      step(mk(S_T1, 16'h0, 16'h0, 14'h0, F_PCOUT | F_INCPC | F_PCIN | F_READ | F_MDRIN),
           "sub_T1", 1'b0, 1'b0);
      step(mk(S_T2, 16'h0, 16'h0, 14'h0, F_MDROUT | F_IRIN), "sub_T2", 1'b0, 1'b0);
      step(mk(S_T3, 16'h0, 16'h0100, 14'h0, F_YIN), "sub_T3", 1'b0, 1'b0);
      step(mk(S_T4, 16'h0, 16'h0200, 14'h0002, F_ZIN), "sub_T4", 1'b0, 1'b0);
      step(mk(S_T5, 16'h0080, 16'h0, 14'h0, F_ZLOW | F_DONE), "sub_T5", 1'b0, 1'b0);
      step(zero, "sub_parked", 1'b0, 1'b0);
      step(zero, "idle_go2", 1'b1, 1'b0);

      // undefined opcode 11111
      fetch("ill", 32'hF8000000);
      step(mk(S_T3, 16'h0, 16'h0, 14'h0, F_DONE | F_ILL), "ill_T3", 1'b1, 1'b0);

      // nop with run low at its last step -> IDLE
      fetch("nop", 32'hD0000000);
      step(mk(S_T3, 16'h0, 16'h0, 14'h0, F_DONE), "nop_T3", 1'b0, 1'b0);
      step(zero, "nop_parked", 1'b1, 1'b0);

      // halt, then run toggling must not leave HALT
      fetch("halt", 32'hD8000000);
      step(mk(S_T3, 16'h0, 16'h0, 14'h0, F_DONE), "halt_T3", 1'b1, 1'b0);
      for (int i = 0; i < 5; i++)
         step(mk(S_HALT, 16'h0, 16'h0, 14'h0, F_HALTED), "halted", logic'(i % 2), 1'b0);
      step(zero, "halt_clear", 1'b1, 1'b1);
      step(zero, "halt_idle", 1'b0, 1'b0);
      step(zero, "idle_go3", 1'b1, 1'b0);

      // clear during T4 of an add
      fetch("addc", 32'h02920000);
      step(mk(S_T3, 16'h0, 16'h0004, 14'h0, F_YIN), "addc_T3", 1'b1, 1'b0);
      step(zero, "addc_T4_clear", 1'b1, 1'b1);
      step(zero, "addc_idle", 1'b0, 1'b0);
      step(zero, "addc_idle2", 1'b0, 1'b0);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
